// File: rtl/dm_resp.sv
// dm_resp: multi-cycle data-memory responder.
//
// Sits at the memory-side end of the pipeline's data-memory port. One read or
// write is accepted at a time and held for LAT busy cycles. While the access is
// in flight, stall_o is raised so the MEM stage and everything upstream freeze.
// The completion cycle (DONE) pulses rdy_o for one cycle with stall_o low, so
// the pipeline advances past the finished instruction.
//
// state | meaning
// IDLE  | no access in flight; a request is accepted at the next edge
// BUSY  | access in flight; cnt_q counts the remaining busy cycles down to 0
// DONE  | access finished; rdy_o high, stall_o low, any request is ignored
//
// Ports:
//   clk_i      - single clock, rising edge
//   rst_ni     - asynchronous active-low reset
//   addr_i     - word address; only the low ADDR_W bits are used
//   re_i       - read request
//   we_i       - write request (wins over re_i when both are high)
//   wrt_data_i - write data
//   rd_data_o  - read data; updated only when a read completes
//   rdy_o      - one-cycle access-complete pulse
//   stall_o    - pipeline freeze request
module dm_resp #(
    parameter int unsigned LAT    = 2,
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] addr_i,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [15:0] wrt_data_i,
    output logic [15:0] rd_data_o,
    output logic        rdy_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         data_q;
    logic                is_wr_q;
    logic [15:0]         rd_data_q;
    logic                rdy_q;
    logic [15:0]         mem_q [2**ADDR_W];

    logic req;
    logic fire;

    assign req  = re_i | we_i;
    assign fire = (state_q == S_BUSY) && (cnt_q == 4'd0);

    // Address bits above ADDR_W alias onto the same word.
    generate
        if (ADDR_W < 16) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr_i[15:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            data_q    <= 16'h0000;
            is_wr_q   <= 1'b0;
            rd_data_q <= 16'h0000;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr_i[ADDR_W-1:0];
                        data_q  <= wrt_data_i;
                        is_wr_q <= we_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!is_wr_q) begin
                            rd_data_q <= mem_q[addr_q];
                        end
                        rdy_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                // The request still visible here belongs to the access that
                // just completed, so it is deliberately not accepted.
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is not reset. A reset during BUSY forces state_q to IDLE,
    // which drops fire, so an aborted write never reaches the array.
    always_ff @(posedge clk_i) begin
        if (fire && is_wr_q) begin
            mem_q[addr_q] <= data_q;
        end
    end

    // Stall is combinational in IDLE so the requesting instruction freezes in
    // the same cycle it presents its request.
    assign stall_o   = rst_ni && (((state_q == S_IDLE) && req) || (state_q == S_BUSY));
    assign rdy_o     = rdy_q;
    assign rd_data_o = rd_data_q;

endmodule
